layer_buffer_reader: RTL

//  Read-side controller for a layer buffer (dual-port BRAM, 8-bit addr, PE_Num*dwidth data).

---
 rtl/layer_buffer_reader_pkg.sv | 15 +
 rtl/layer_buffer_reader_fifo.sv | 61 ++++++
 rtl/layer_buffer_reader.sv | 129 ++++++++++++
 3 files changed

// File: rtl/layer_buffer_reader_pkg.sv
// Shared constants and types for the layer buffer read-side controller.
package layer_buffer_reader_pkg;

   localparam int LB_AW = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } lb_state_t;

   function automatic int lb_word_w(input int pe_num, input int dw);
      return pe_num * dw;
   endfunction

endpackage

// File: rtl/layer_buffer_reader_fifo.sv
// Synchronous output FIFO for buffer words plus their last tag.
module lb_rd_fifo #(
   parameter int W          = 128,
   parameter int FIFO_DEPTH = 4,
   parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          din_last,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          dout_last,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [W-1:0]          mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] last_mem;
   logic [AW-1:0]         wptr;
   logic [AW-1:0]         rptr;
   logic                  do_pop;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty     = (count == '0);
   assign do_pop    = pop && !empty;
   assign dout      = mem[rptr];
   assign dout_last = last_mem[rptr] && !empty;

   // Upstream credit accounting guarantees push never lands on a full FIFO without a pop.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         last_mem <= '0;
      end else begin
         if (push) begin
            last_mem[wptr] <= din_last;
            wptr           <= nxt(wptr);
         end
         if (do_pop) rptr <= nxt(rptr);
         unique case ({push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/layer_buffer_reader.sv
// Streams len words from base_addr of the layer buffer to the PE array.
//  state | meaning
//  IDLE  | waiting for start; len=0 start only pulses done
//  RUN   | issuing reads under FIFO credit and delivering words until the last handshake
module layer_buffer_reader
   import layer_buffer_reader_pkg::*;
#(
   parameter int dwidth     = 16,
   parameter int PE_Num     = 8,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [7:0]               base_addr,
   input  logic [8:0]               len,
   output logic                     busy,
   output logic                     done,
   output logic [7:0]               layer_buffer_raddr,
   input  logic [PE_Num*dwidth-1:0] rdata,
   output logic [PE_Num*dwidth-1:0] dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic                     dout_last
);

   localparam int W  = lb_word_w(PE_Num, dwidth);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   lb_state_t        state;
   logic [LB_AW-1:0] base_q;
   logic [8:0]       len_q;
   logic [8:0]       issue_cnt;
   logic [8:0]       recv_cnt;
   logic [RD_LAT-1:0] tag_v;
   logic [RD_LAT-1:0] tag_l;
   logic [CW-1:0]    fifo_count;
   logic             fifo_empty;
   logic             hs;
   logic             issue;
   logic             issue_last;
   logic [CW+1:0]    credit;

   assign hs         = dout_valid && dout_ready;
   assign dout_valid = !fifo_empty;
   assign issue_last = (issue_cnt == len_q - 9'd1);

   // A word popped this edge frees its slot for the read issued on the same edge.
   always_comb begin
      credit = (CW+2)'($countones(tag_v)) + (CW+2)'(fifo_count) - (CW+2)'(hs);
      issue  = (state == RUN) && (issue_cnt < len_q) && (credit < (CW+2)'(FIFO_DEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         busy               <= 1'b0;
         done               <= 1'b0;
         base_q             <= '0;
         len_q              <= '0;
         issue_cnt          <= '0;
         recv_cnt           <= '0;
         layer_buffer_raddr <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (len == 9'd0) begin
                     done <= 1'b1;
                  end else begin
                     state     <= RUN;
                     busy      <= 1'b1;
                     base_q    <= base_addr;
                     len_q     <= len;
                     issue_cnt <= '0;
                     recv_cnt  <= '0;
                  end
               end
            end
            RUN: begin
               if (issue) begin
                  layer_buffer_raddr <= base_q + issue_cnt[LB_AW-1:0];
                  issue_cnt          <= issue_cnt + 9'd1;
               end
               if (hs) begin
                  recv_cnt <= recv_cnt + 9'd1;
                  if (recv_cnt == len_q - 9'd1) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // raddr acts as the BRAM address register; a tag leaving the last stage marks valid rdata.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v <= '0;
         tag_l <= '0;
      end else begin
         tag_v <= (tag_v << 1) | RD_LAT'(issue);
         tag_l <= (tag_l << 1) | RD_LAT'(issue && issue_last);
      end
   end

   lb_rd_fifo #(
      .W          (W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CW         (CW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (tag_v[RD_LAT-1]),
      .din       (rdata),
      .din_last  (tag_l[RD_LAT-1]),
      .pop       (dout_ready),
      .dout      (dout),
      .dout_last (dout_last),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule
